// File: rtl/pueo_cmpl_pkg.sv
// Shared types for the completion merger: beat field positions, state table entry, FSM states.
package pueo_cmpl_pkg;

  localparam int CMPL_TDATA_W  = 24;
  localparam int CMPL_ADDR_LSB = 8;
  localparam int CMPL_ADDR_W   = 13;
  localparam int CMPL_ERR_W    = 4;

  typedef struct packed {
    logic                  hseen;
    logic [CMPL_ERR_W-1:0] herr;
    logic                  dseen;
    logic [CMPL_ERR_W-1:0] derr;
  } cmpl_entry_t;

  typedef enum logic {
    SRC_HDR = 1'b0,
    SRC_DAT = 1'b1
  } src_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CHECK = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  function automatic logic [CMPL_ERR_W-1:0] cmpl_err(input logic [CMPL_TDATA_W-1:0] tdata);
    return tdata[CMPL_ERR_W-1:0];
  endfunction

endpackage

// File: rtl/cmpl_state_ram.sv
// Per-address completion state table: single port, registered read, write-first, no reset.
module cmpl_state_ram #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_W    = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_q   <= wdata;
      end else begin
        rdata_q   <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/event_cmpl_merger.sv
// Joins header and data completion streams per buffer address and emits one event-done
// beat once both halves of an address have completed.
//   state    | meaning
//   ST_INIT  | sweeping the state table to zero, inputs blocked
//   ST_IDLE  | arbitrating between header and data completions
//   ST_READ  | waiting for the table entry of the accepted address
//   ST_CHECK | classify: duplicate, pair complete, or first half
//   ST_EMIT  | holding the event-done beat until the consumer takes it
module event_cmpl_merger
  import pueo_cmpl_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int CNT_WIDTH = 32
) (
  input  logic                    memclk,
  input  logic                    memrst,
  input  logic [CMPL_TDATA_W-1:0] s_hcmpl_tdata,
  input  logic                    s_hcmpl_tvalid,
  output logic                    s_hcmpl_tready,
  input  logic [CMPL_TDATA_W-1:0] s_dcmpl_tdata,
  input  logic                    s_dcmpl_tvalid,
  output logic                    s_dcmpl_tready,
  output logic [CMPL_TDATA_W-1:0] m_evdone_tdata,
  output logic                    m_evdone_tvalid,
  input  logic                    m_evdone_tready,
  output logic                    init_done_o,
  output logic [CNT_WIDTH-1:0]    ev_count_o,
  output logic [15:0]             err_count_o,
  output logic [15:0]             dup_count_o
);

  localparam int ENTRY_W = $bits(cmpl_entry_t);

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  src_e                    rr_last_q, rr_last_d;
  src_e                    src_q, src_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [CMPL_ERR_W-1:0]   err_q, err_d;
  logic [CMPL_TDATA_W-1:0] evd_tdata_q, evd_tdata_d;
  logic                    evd_tvalid_q, evd_tvalid_d;
  logic [CNT_WIDTH-1:0]    ev_cnt_q, ev_cnt_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [15:0]             dup_cnt_q, dup_cnt_d;

  src_e                    pick;
  logic [CMPL_TDATA_W-1:0] acc_data;
  logic                    in_idle;
  logic                    unused_bits;

  logic                    ram_en, ram_we;
  logic [ADDR_BITS-1:0]    ram_addr;
  logic [ENTRY_W-1:0]      ram_wdata, ram_rdata;

  cmpl_entry_t             ent, new_ent;
  logic                    own_seen, oth_seen;
  logic [CMPL_ERR_W-1:0]   herr_out, derr_out;
  logic [CMPL_TDATA_W-1:0] evd_word;

  // Arbiter: a tie goes to the source that did not win the last accept.
  always_comb begin
    if (s_hcmpl_tvalid && s_dcmpl_tvalid) pick = (rr_last_q == SRC_DAT) ? SRC_HDR : SRC_DAT;
    else if (s_hcmpl_tvalid)              pick = SRC_HDR;
    else                                  pick = SRC_DAT;
  end

  assign in_idle        = (state_q == ST_IDLE);
  assign s_hcmpl_tready = in_idle && s_hcmpl_tvalid && (pick == SRC_HDR);
  assign s_dcmpl_tready = in_idle && s_dcmpl_tvalid && (pick == SRC_DAT);
  assign acc_data       = (pick == SRC_HDR) ? s_hcmpl_tdata : s_dcmpl_tdata;
  assign unused_bits    = ^{acc_data[CMPL_TDATA_W-1:CMPL_ADDR_LSB+ADDR_BITS],
                            acc_data[CMPL_ADDR_LSB-1:CMPL_ERR_W]};

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_done_d  = init_done_q;
    rr_last_d    = rr_last_q;
    src_d        = src_q;
    addr_d       = addr_q;
    err_d        = err_q;
    evd_tdata_d  = evd_tdata_q;
    evd_tvalid_d = evd_tvalid_q;
    ev_cnt_d     = ev_cnt_q;
    err_cnt_d    = err_cnt_q;
    dup_cnt_d    = dup_cnt_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr_q;
    ram_wdata    = '0;
    ent          = cmpl_entry_t'(ram_rdata);
    new_ent      = ent;
    own_seen     = (src_q == SRC_HDR) ? ent.hseen : ent.dseen;
    oth_seen     = (src_q == SRC_HDR) ? ent.dseen : ent.hseen;
    herr_out     = (src_q == SRC_HDR) ? err_q : ent.herr;
    derr_out     = (src_q == SRC_DAT) ? err_q : ent.derr;
    evd_word     = '0;
    evd_word[CMPL_ADDR_LSB +: ADDR_BITS]    = addr_q;
    evd_word[CMPL_ERR_W +: CMPL_ERR_W]      = herr_out;
    evd_word[CMPL_ERR_W-1:0]                = derr_out;

    case (state_q)
      ST_INIT: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + ADDR_BITS'(1);
        if (init_cnt_q == {ADDR_BITS{1'b1}}) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (s_hcmpl_tready || s_dcmpl_tready) begin
          ram_en    = 1'b1;
          ram_addr  = acc_data[CMPL_ADDR_LSB +: ADDR_BITS];
          addr_d    = acc_data[CMPL_ADDR_LSB +: ADDR_BITS];
          err_d     = cmpl_err(acc_data);
          src_d     = pick;
          rr_last_d = pick;
          state_d   = ST_READ;
        end
      end
      ST_READ: state_d = ST_CHECK;
      ST_CHECK: begin
        if (own_seen) begin
          if (dup_cnt_q != 16'hFFFF) dup_cnt_d = dup_cnt_q + 16'd1;
          state_d = ST_IDLE;
        end else if (oth_seen) begin
          // Clearing on emit lets the address be reused for the next event.
          ram_en       = 1'b1;
          ram_we       = 1'b1;
          evd_tdata_d  = evd_word;
          evd_tvalid_d = 1'b1;
          state_d      = ST_EMIT;
        end else begin
          if (src_q == SRC_HDR) begin
            new_ent.hseen = 1'b1;
            new_ent.herr  = err_q;
          end else begin
            new_ent.dseen = 1'b1;
            new_ent.derr  = err_q;
          end
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = new_ent;
          state_d   = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (m_evdone_tready) begin
          evd_tvalid_d = 1'b0;
          ev_cnt_d     = ev_cnt_q + CNT_WIDTH'(1);
          if (evd_tdata_q[2*CMPL_ERR_W-1:0] != '0 && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge memclk or posedge memrst) begin
    if (memrst) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      rr_last_q    <= SRC_DAT;
      src_q        <= SRC_HDR;
      addr_q       <= '0;
      err_q        <= '0;
      evd_tdata_q  <= '0;
      evd_tvalid_q <= 1'b0;
      ev_cnt_q     <= '0;
      err_cnt_q    <= '0;
      dup_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      rr_last_q    <= rr_last_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      evd_tdata_q  <= evd_tdata_d;
      evd_tvalid_q <= evd_tvalid_d;
      ev_cnt_q     <= ev_cnt_d;
      err_cnt_q    <= err_cnt_d;
      dup_cnt_q    <= dup_cnt_d;
    end
  end

  cmpl_state_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (ENTRY_W)
  ) u_state_ram (
    .clk   (memclk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign m_evdone_tdata  = evd_tdata_q;
  assign m_evdone_tvalid = evd_tvalid_q;
  assign init_done_o     = init_done_q;
  assign ev_count_o      = ev_cnt_q;
  assign err_count_o     = err_cnt_q;
  assign dup_count_o     = dup_cnt_q;

endmodule

// File: tb/tb_event_cmpl_merger.sv
// Directed bench for event_cmpl_merger: init sweep, pairing, arbitration, duplicates,
// backpressure and reset during a pending event.
module tb_event_cmpl_merger;

  logic        memclk = 1'b0;
  logic        memrst = 1'b1;
  logic [23:0] s_hcmpl_tdata = '0;
  logic        s_hcmpl_tvalid = 1'b0;
  logic        s_hcmpl_tready;
  logic [23:0] s_dcmpl_tdata = '0;
  logic        s_dcmpl_tvalid = 1'b0;
  logic        s_dcmpl_tready;
  logic [23:0] m_evdone_tdata;
  logic        m_evdone_tvalid;
  logic        m_evdone_tready = 1'b1;
  logic        init_done_o;
  logic [31:0] ev_count_o;
  logic [15:0] err_count_o;
  logic [15:0] dup_count_o;

  int total = 0;
  int bad   = 0;

  logic [23:0] h_vec [16];
  logic [23:0] d_vec [16];
  logic [23:0] ev_q [$];
  bit          acc_q [$];

  event_cmpl_merger #(.ADDR_BITS(13), .CNT_WIDTH(32)) dut (
    .memclk          (memclk),
    .memrst          (memrst),
    .s_hcmpl_tdata   (s_hcmpl_tdata),
    .s_hcmpl_tvalid  (s_hcmpl_tvalid),
    .s_hcmpl_tready  (s_hcmpl_tready),
    .s_dcmpl_tdata   (s_dcmpl_tdata),
    .s_dcmpl_tvalid  (s_dcmpl_tvalid),
    .s_dcmpl_tready  (s_dcmpl_tready),
    .m_evdone_tdata  (m_evdone_tdata),
    .m_evdone_tvalid (m_evdone_tvalid),
    .m_evdone_tready (m_evdone_tready),
    .init_done_o     (init_done_o),
    .ev_count_o      (ev_count_o),
    .err_count_o     (err_count_o),
    .dup_count_o     (dup_count_o)
  );

  always #5 memclk = ~memclk;

  // Inputs only change just after a rising edge, so the negedge view equals the handshake at the next edge.
  always @(negedge memclk) begin
    if (m_evdone_tvalid && m_evdone_tready) ev_q.push_back(m_evdone_tdata);
    if (s_hcmpl_tvalid && s_hcmpl_tready)   acc_q.push_back(1'b0);
    if (s_dcmpl_tvalid && s_dcmpl_tready)   acc_q.push_back(1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] cm(input logic [12:0] addr, input logic [3:0] err);
    return {3'b000, addr, 4'h0, err};
  endfunction

  task automatic drive_src(input int src, input int n);
    int waitc;
    @(posedge memclk); #1;
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin s_hcmpl_tdata = h_vec[i]; s_hcmpl_tvalid = 1'b1; end
      else          begin s_dcmpl_tdata = d_vec[i]; s_dcmpl_tvalid = 1'b1; end
      waitc = 0;
      @(negedge memclk);
      while (!((src == 0) ? s_hcmpl_tready : s_dcmpl_tready) && waitc < 300) begin
        waitc++;
        @(negedge memclk);
      end
      if (waitc >= 300) begin
        chk("hs_timeout", waitc, 0);
        break;
      end
      @(posedge memclk); #1;
    end
    if (src == 0) s_hcmpl_tvalid = 1'b0;
    else          s_dcmpl_tvalid = 1'b0;
  endtask

  task automatic settle();
    repeat (10) @(negedge memclk);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    @(negedge memclk);
    while (!init_done_o && n < 9000) begin
      n++;
      @(negedge memclk);
    end
    chk("reinit_done", init_done_o, 1);
  endtask

  initial begin
    int n;
    int trdy_bad;
    int base;
    int abase;

    // Reset values, with both sources offering beats that must not be taken.
    s_hcmpl_tdata = cm(13'h0001, 4'h0); s_hcmpl_tvalid = 1'b1;
    s_dcmpl_tdata = cm(13'h0001, 4'h0); s_dcmpl_tvalid = 1'b1;
    repeat (3) @(negedge memclk);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_tready", {s_hcmpl_tready, s_dcmpl_tready}, 0);
    chk("rst_evvalid", m_evdone_tvalid, 0);
    chk("rst_counts", {ev_count_o[15:0], err_count_o | dup_count_o}, 0);

    @(posedge memclk); #1 memrst = 1'b0;
    n = 0; trdy_bad = 0;
    @(negedge memclk);
    while (!init_done_o && n < 9000) begin
      if (s_hcmpl_tready || s_dcmpl_tready) trdy_bad++;
      n++;
      if (n == 8000) begin
        @(posedge memclk); #1;
        s_hcmpl_tvalid = 1'b0; s_dcmpl_tvalid = 1'b0;
      end
      @(negedge memclk);
    end
    chk("init_cycles", n, 8192);
    chk("init_tready", trdy_bad, 0);
    chk("init_done", init_done_o, 1);
    settle();
    chk("init_no_accept", acc_q.size(), 0);

    // Simple pair
    base = ev_q.size();
    h_vec[0] = cm(13'h0123, 4'h0); drive_src(0, 1);
    d_vec[0] = cm(13'h0123, 4'h0); drive_src(1, 1);
    settle();
    chk("pair_nev", ev_q.size() - base, 1);
    if (ev_q.size() > base) chk("pair_tdata", ev_q[base], 24'h012300);
    chk("pair_evcnt", ev_count_o, 1);

    // Tie arbitration with interleaved addresses
    base = ev_q.size(); abase = acc_q.size();
    h_vec[0] = cm(13'h0010, 0); h_vec[1] = cm(13'h0011, 0); h_vec[2] = cm(13'h0012, 0); h_vec[3] = cm(13'h0013, 0);
    d_vec[0] = cm(13'h0011, 0); d_vec[1] = cm(13'h0010, 0); d_vec[2] = cm(13'h0013, 0); d_vec[3] = cm(13'h0012, 0);
    fork
      drive_src(0, 4);
      drive_src(1, 4);
    join
    settle();
    chk("tie_nacc", acc_q.size() - abase, 8);
    for (int i = 0; i < 8; i++)
      if (abase + i < acc_q.size()) chk($sformatf("tie_acc%0d", i), acc_q[abase + i], i % 2);
    chk("tie_nev", ev_q.size() - base, 4);
    if (ev_q.size() >= base + 4) begin
      chk("tie_ev0", ev_q[base],     24'h001100);
      chk("tie_ev1", ev_q[base + 1], 24'h001000);
      chk("tie_ev2", ev_q[base + 2], 24'h001300);
      chk("tie_ev3", ev_q[base + 3], 24'h001200);
    end
    chk("tie_evcnt", ev_count_o, 5);

    // Errors, data first, with junk in the ignored bits
    base = ev_q.size();
    d_vec[0] = {3'b101, 13'h1FFF, 4'hF, 4'h2}; drive_src(1, 1);
    h_vec[0] = {3'b011, 13'h1FFF, 4'hA, 4'h8}; drive_src(0, 1);
    settle();
    chk("err_nev", ev_q.size() - base, 1);
    if (ev_q.size() > base) chk("err_tdata", ev_q[base], 24'h1FFF82);
    chk("err_errcnt", err_count_o, 1);
    chk("err_evcnt", ev_count_o, 6);

    // Duplicate header
    base = ev_q.size();
    h_vec[0] = cm(13'h0005, 4'h0);
    drive_src(0, 1);
    drive_src(0, 1);
    settle();
    chk("dup_cnt", dup_count_o, 1);
    chk("dup_noev", ev_q.size() - base, 0);
    d_vec[0] = cm(13'h0005, 4'h0); drive_src(1, 1);
    settle();
    chk("dup_close_nev", ev_q.size() - base, 1);
    if (ev_q.size() > base) chk("dup_close_tdata", ev_q[base], 24'h000500);
    chk("dup_evcnt", ev_count_o, 7);

    // Backpressure: ten pairs behind a stalled consumer
    base = ev_q.size();
    for (int i = 0; i < 10; i++) begin
      h_vec[i] = cm(13'(32 + i), 4'h0);
      d_vec[i] = cm(13'(32 + i), 4'h0);
    end
    m_evdone_tready = 1'b0;
    fork
      drive_src(0, 10);
      drive_src(1, 10);
      begin
        repeat (30) @(negedge memclk);
        chk("bp_hold_valid", m_evdone_tvalid, 1);
        chk("bp_hold_tdata", m_evdone_tdata, 24'h002000);
        chk("bp_hold_tready", {s_hcmpl_tready, s_dcmpl_tready}, 0);
        repeat (20) @(posedge memclk);
        #1 m_evdone_tready = 1'b1;
      end
    join
    settle();
    chk("bp_nev", ev_q.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < ev_q.size()) chk($sformatf("bp_ev%0d", i), ev_q[base + i], 32'(cm(13'(32 + i), 4'h0)));
    chk("bp_evcnt", ev_count_o, 17);
    chk("bp_errcnt", err_count_o, 1);

    // Reset while an event is pending
    m_evdone_tready = 1'b0;
    h_vec[0] = cm(13'h0042, 4'h0); drive_src(0, 1);
    d_vec[0] = cm(13'h0042, 4'h0); drive_src(1, 1);
    repeat (5) @(negedge memclk);
    chk("mid_pending", m_evdone_tvalid, 1);
    base = ev_q.size();
    @(posedge memclk); #1 memrst = 1'b1;
    #1;
    chk("mid_valid_drop", m_evdone_tvalid, 0);
    chk("mid_init_clr", init_done_o, 0);
    chk("mid_evcnt_clr", ev_count_o, 0);
    repeat (3) @(posedge memclk);
    #1 memrst = 1'b0; m_evdone_tready = 1'b1;
    wait_init();
    h_vec[0] = cm(13'h0042, 4'h1); drive_src(0, 1);
    d_vec[0] = cm(13'h0042, 4'h0); drive_src(1, 1);
    settle();
    chk("mid_nev", ev_q.size() - base, 1);
    if (ev_q.size() > base) chk("mid_tdata", ev_q[base], 24'h004210);
    chk("mid_evcnt", ev_count_o, 1);
    chk("mid_errcnt", err_count_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
